hm_cpl: RTL and testbench

- Completer-side counterpart of the host-memory read engine. It sits on the same 64-bit TRN interface and answers inbound single-DW Memory Read requests that hit one BAR.
- For each request it reads one 32-bit word from a local synchronous memory port and returns a 3DW-header CplD TLP.
- Requests are handled strictly one at a time. Everything else arriving on RX is consumed and counted as dropped.

---
 rtl/hm_cpl_if.sv | 43 ++++
 rtl/hm_cpl.sv | 212 +++++++++++++++++++++
 tb/tb_hm_cpl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hm_cpl_if.sv
// rtl/hm_cpl_if.sv - TRN RX/TX link bundle between the PCIe core and the hm_cpl completer.
interface hm_cpl_if;
    logic [63:0] trn_rd;
    logic        trn_rrem_n;
    logic        trn_rsof_n;
    logic        trn_reof_n;
    logic        trn_rsrc_rdy_n;
    logic        trn_rsrc_dsc_n;
    logic        trn_rerrfwd_n;
    logic [6:0]  trn_rbar_hit_n;
    logic        trn_rdst_rdy_n;
    logic        trn_rnp_ok_n;

    logic [63:0] trn_td;
    logic        trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;
    logic [5:0]  trn_tbuf_av;
    logic        trn_tsrc_dsc_n;
    logic        trn_terrfwd_n;
    logic        trn_tstr_n;
    logic        trn_tcfg_gnt_n;

    modport slave (
        input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n,
               trn_rsrc_dsc_n, trn_rerrfwd_n, trn_rbar_hit_n,
               trn_tdst_rdy_n, trn_tbuf_av,
        output trn_rdst_rdy_n, trn_rnp_ok_n,
               trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
               trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n, trn_tcfg_gnt_n
    );

    modport master (
        output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n,
               trn_rsrc_dsc_n, trn_rerrfwd_n, trn_rbar_hit_n,
               trn_tdst_rdy_n, trn_tbuf_av,
        input  trn_rdst_rdy_n, trn_rnp_ok_n,
               trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
               trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n, trn_tcfg_gnt_n
    );
endinterface

// File: rtl/hm_cpl.sv
// rtl/hm_cpl.sv - Single-DW MemRd completer: reads one local word and returns a 3DW CplD.
module hm_cpl #(
    parameter int bar_index = 0,
    parameter int mem_aw    = 10
) (
    input  logic              trn_clk,
    input  logic              trn_reset_n,
    input  logic              trn_lnk_up_n,
    hm_cpl_if.slave           trn,
    input  logic [7:0]        cfg_bus_number,
    input  logic [4:0]        cfg_device_number,
    input  logic [2:0]        cfg_function_number,
    output logic [mem_aw-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_data,
    output logic [31:0]       stat_cpl_cnt,
    output logic [31:0]       stat_drop_cnt,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR2, S_DROP, S_READ, S_WAIT, S_TX0, S_TX1
    } state_t;

    state_t state, state_nxt;

    logic [31:0] rx_dw0, rx_dw1;
    logic [1:0]  rx_fmt;
    logic [4:0]  rx_type;
    logic [9:0]  rx_len;
    logic        rx_qual, rx_accept, rx_sof, rx_eof, rx_dsc;
    logic        tx_ready, tx0_done, tx1_done;
    logic        drop_inc, cpl_inc;

    logic [2:0]  tc_q;
    logic [1:0]  attr_q;
    logic [15:0] req_id_q;
    logic [7:0]  tag_q;
    logic [3:0]  first_be_q;
    logic        is64_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;

    logic [11:0] byte_cnt;
    logic [1:0]  low_lo;
    logic [31:0] cpl_dw0, cpl_dw1, cpl_dw2;

    assign rx_dw0  = trn.trn_rd[63:32];
    assign rx_dw1  = trn.trn_rd[31:0];
    assign rx_fmt  = rx_dw0[30:29];
    assign rx_type = rx_dw0[28:24];
    assign rx_len  = rx_dw0[9:0];

    assign rx_qual = (rx_fmt == 2'b00 || rx_fmt == 2'b01) && (rx_type == 5'b00000) &&
                     (rx_len == 10'd1) && !trn.trn_rbar_hit_n[bar_index] && trn.trn_rerrfwd_n;

    assign rx_accept = !trn.trn_rsrc_rdy_n && !trn.trn_rdst_rdy_n;
    assign rx_sof    = rx_accept && !trn.trn_rsof_n;
    assign rx_eof    = rx_accept && !trn.trn_reof_n;
    assign rx_dsc    = !trn.trn_rsrc_dsc_n;

    assign tx_ready  = !trn.trn_tdst_rdy_n;
    assign tx0_done  = (state == S_TX0) && (trn.trn_tbuf_av != 6'd0) && tx_ready;
    assign tx1_done  = (state == S_TX1) && tx_ready;

    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Link loss overrides every state; an in-flight request is simply abandoned.
    always_comb begin
        state_nxt = state;
        if (trn_lnk_up_n) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_sof) begin
                        if (rx_eof)       state_nxt = S_IDLE;
                        else if (rx_qual) state_nxt = S_HDR2;
                        else              state_nxt = S_DROP;
                    end
                end
                S_HDR2: begin
                    if (rx_dsc)         state_nxt = S_IDLE;
                    else if (rx_accept) state_nxt = rx_eof ? S_READ : S_DROP;
                end
                S_DROP: begin
                    if (rx_dsc || rx_eof) state_nxt = S_IDLE;
                end
                S_READ:  state_nxt = S_WAIT;
                S_WAIT:  state_nxt = S_TX0;
                S_TX0:   if (tx0_done) state_nxt = S_TX1;
                S_TX1:   if (tx1_done) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        trn.trn_rdst_rdy_n = !(state == S_IDLE || state == S_HDR2 || state == S_DROP);
        trn.trn_td         = 64'd0;
        trn.trn_trem_n     = 1'b0;
        trn.trn_tsof_n     = 1'b1;
        trn.trn_teof_n     = 1'b1;
        trn.trn_tsrc_rdy_n = 1'b1;
        mem_re             = 1'b0;
        mem_addr           = '0;
        busy               = (state != S_IDLE);
        case (state)
            S_READ: begin
                mem_re   = 1'b1;
                mem_addr = addr_q[mem_aw+1:2];
            end
            S_TX0: begin
                trn.trn_td = {cpl_dw0, cpl_dw1};
                if (trn.trn_tbuf_av != 6'd0) begin
                    trn.trn_tsrc_rdy_n = 1'b0;
                    trn.trn_tsof_n     = 1'b0;
                end
            end
            S_TX1: begin
                trn.trn_td         = {cpl_dw2, data_q};
                trn.trn_tsrc_rdy_n = 1'b0;
                trn.trn_teof_n     = 1'b0;
            end
            default: ;
        endcase
    end

    assign trn.trn_rnp_ok_n   = 1'b0;
    assign trn.trn_tsrc_dsc_n = 1'b1;
    assign trn.trn_terrfwd_n  = 1'b1;
    assign trn.trn_tstr_n     = 1'b1;
    assign trn.trn_tcfg_gnt_n = 1'b0;

    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            tc_q       <= 3'd0;
            attr_q     <= 2'd0;
            req_id_q   <= 16'd0;
            tag_q      <= 8'd0;
            first_be_q <= 4'd0;
            is64_q     <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
        end else begin
            if (state == S_IDLE && rx_sof && !rx_eof && rx_qual) begin
                tc_q       <= rx_dw0[22:20];
                attr_q     <= rx_dw0[13:12];
                req_id_q   <= rx_dw1[31:16];
                tag_q      <= rx_dw1[15:8];
                first_be_q <= rx_dw1[3:0];
                is64_q     <= rx_fmt[0];
            end
            if (state == S_HDR2 && !rx_dsc && rx_eof) begin
                addr_q <= is64_q ? rx_dw1 : rx_dw0;
            end
            // TRN carries payload big-endian, the local memory is little-endian.
            if (state == S_WAIT) begin
                data_q <= {mem_data[7:0], mem_data[15:8], mem_data[23:16], mem_data[31:24]};
            end
        end
    end

    assign drop_inc = !trn_lnk_up_n &&
                      ((state == S_IDLE && rx_sof && rx_eof) ||
                       ((state == S_HDR2 || state == S_DROP) && rx_dsc) ||
                       (state == S_DROP && rx_eof));
    assign cpl_inc  = !trn_lnk_up_n && tx1_done;

    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            stat_cpl_cnt  <= 32'd0;
            stat_drop_cnt <= 32'd0;
        end else begin
            if (cpl_inc)  stat_cpl_cnt  <= stat_cpl_cnt + 32'd1;
            if (drop_inc) stat_drop_cnt <= stat_drop_cnt + 32'd1;
        end
    end

    always_comb begin
        casez (first_be_q)
            4'b1??1:                     byte_cnt = 12'd4;
            4'b01?1, 4'b1?10:            byte_cnt = 12'd3;
            4'b0011, 4'b0110, 4'b1100:   byte_cnt = 12'd2;
            default:                     byte_cnt = 12'd1;
        endcase
    end

    always_comb begin
        casez (first_be_q)
            4'b???1: low_lo = 2'd0;
            4'b??10: low_lo = 2'd1;
            4'b?100: low_lo = 2'd2;
            4'b1000: low_lo = 2'd3;
            default: low_lo = 2'd0;
        endcase
    end

    assign cpl_dw0 = {1'b0, 2'b10, 5'b01010, 1'b0, tc_q, 4'b0000, 2'b00, attr_q, 2'b00, 10'd1};
    assign cpl_dw1 = {cfg_bus_number, cfg_device_number, cfg_function_number, 3'b000, 1'b0, byte_cnt};
    assign cpl_dw2 = {req_id_q, tag_q, 1'b0, addr_q[6:2], low_lo};

    logic unused_bits;
    assign unused_bits = ^{trn.trn_rd, trn.trn_rrem_n, trn.trn_rbar_hit_n, addr_q};

endmodule

// File: tb/tb_hm_cpl.sv
// tb/tb_hm_cpl.sv - Directed self-checking bench for the hm_cpl completer.
module tb_hm_cpl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lnk_up_n;
    logic [7:0]  bus_num;
    logic [4:0]  dev_num;
    logic [2:0]  func_num;
    logic [9:0]  mem_addr;
    logic        mem_re;
    logic [31:0] mem_data;
    logic [31:0] stat_cpl_cnt;
    logic [31:0] stat_drop_cnt;
    logic        busy;

    hm_cpl_if trn_bus();

    hm_cpl #(.bar_index(0), .mem_aw(10)) dut (
        .trn_clk            (clk),
        .trn_reset_n        (rst_n),
        .trn_lnk_up_n       (lnk_up_n),
        .trn                (trn_bus),
        .cfg_bus_number     (bus_num),
        .cfg_device_number  (dev_num),
        .cfg_function_number(func_num),
        .mem_addr           (mem_addr),
        .mem_re             (mem_re),
        .mem_data           (mem_data),
        .stat_cpl_cnt       (stat_cpl_cnt),
        .stat_drop_cnt      (stat_drop_cnt),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    always @(posedge clk) if (mem_re) mem_data <= mem[mem_addr];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          re_cyc = 0;
    int          sof_cyc = 0;
    int          teof_cyc = 0;
    int          acc_cyc = 0;
    logic [9:0]  re_addr = 10'd0;
    logic [63:0] tx_q[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_re) begin
            re_cyc  = cyc;
            re_addr = mem_addr;
        end
        if (rst_n && !trn_bus.trn_tsrc_rdy_n && !trn_bus.trn_tdst_rdy_n) begin
            tx_q.push_back(trn_bus.trn_td);
            if (!trn_bus.trn_tsof_n) sof_cyc = cyc;
            if (!trn_bus.trn_teof_n) teof_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic sof, input logic eof, input logic dsc);
        int t = 0;
        trn_bus.trn_rd         = d;
        trn_bus.trn_rsof_n     = !sof;
        trn_bus.trn_reof_n     = !eof;
        trn_bus.trn_rsrc_dsc_n = !dsc;
        trn_bus.trn_rsrc_rdy_n = 1'b0;
        #1;
        while (trn_bus.trn_rdst_rdy_n && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("rx_ready", {63'd0, trn_bus.trn_rdst_rdy_n}, 64'd0);
        @(posedge clk); #1;
        acc_cyc = cyc;
        trn_bus.trn_rsrc_rdy_n = 1'b1;
        trn_bus.trn_rsof_n     = 1'b1;
        trn_bus.trn_reof_n     = 1'b1;
        trn_bus.trn_rsrc_dsc_n = 1'b1;
    endtask

    task automatic mrd32(input logic [31:0] addr, input logic [7:0] tag, input logic [3:0] be,
                         input logic [15:0] rid, input logic [2:0] tc);
        send_beat({1'b0, 2'b00, 5'b00000, 1'b0, tc, 4'b0, 6'b0, 10'd1, rid, tag, 4'b0, be}, 1'b1, 1'b0, 1'b0);
        send_beat({addr, 32'h0}, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    int q0, eof_n, c0, d0;
    logic [63:0] hdr;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5A000000 | i;
        mem[4]     = 32'h11223344;
        mem[8]     = 32'hCAFEBABE;
        mem[10'h3FF] = 32'hA1B2C3D4;

        rst_n = 1'b0; lnk_up_n = 1'b0;
        bus_num = 8'h02; dev_num = 5'd0; func_num = 3'd0;
        trn_bus.trn_rd = 64'd0; trn_bus.trn_rrem_n = 1'b0;
        trn_bus.trn_rsof_n = 1'b1; trn_bus.trn_reof_n = 1'b1;
        trn_bus.trn_rsrc_rdy_n = 1'b1; trn_bus.trn_rsrc_dsc_n = 1'b1;
        trn_bus.trn_rerrfwd_n = 1'b1; trn_bus.trn_rbar_hit_n = 7'h7E;
        trn_bus.trn_tdst_rdy_n = 1'b0; trn_bus.trn_tbuf_av = 6'd4;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // reset state
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_tx_ctl", {60'd0, trn_bus.trn_tsrc_rdy_n, trn_bus.trn_tsof_n, trn_bus.trn_teof_n, trn_bus.trn_trem_n}, 64'hE);
        check("rst_td", trn_bus.trn_td, 64'd0);
        check("rst_mem", {53'd0, mem_re, mem_addr}, 64'd0);
        check("rst_cnt", {stat_cpl_cnt, stat_drop_cnt}, 64'd0);
        check("rst_rx_rdy", {63'd0, trn_bus.trn_rdst_rdy_n}, 64'd0);
        check("ties", {59'd0, trn_bus.trn_rnp_ok_n, trn_bus.trn_tsrc_dsc_n, trn_bus.trn_terrfwd_n,
                       trn_bus.trn_tstr_n, trn_bus.trn_tcfg_gnt_n}, 64'hE);

        // MRd32 with latency checks
        q0 = tx_q.size();
        mrd32(32'h10, 8'h05, 4'b1111, 16'h0100, 3'd0);
        eof_n = acc_cyc;
        wait_idle();
        check("m32_nbeats", tx_q.size() - q0, 64'd2);
        if (tx_q.size() >= q0 + 2) begin
            check("m32_beat0", tx_q[q0], 64'h4A000001_02000004);
            check("m32_beat1", tx_q[q0+1], 64'h01000510_44332211);
        end
        check("m32_re_lat", re_cyc - eof_n, 64'd1);
        check("m32_sof_lat", sof_cyc - eof_n, 64'd3);
        check("m32_eof_lat", teof_cyc - eof_n, 64'd4);
        check("m32_addr", {54'd0, re_addr}, 64'd4);
        check("m32_cpl", {32'd0, stat_cpl_cnt}, 64'd1);

        // MRd64, TC=2, BE 0110
        q0 = tx_q.size();
        send_beat({1'b0, 2'b01, 5'b00000, 1'b0, 3'd2, 4'b0, 6'b0, 10'd1, 16'h1234, 8'h22, 4'h0, 4'b0110}, 1'b1, 1'b0, 1'b0);
        send_beat({32'h0000_0001, 32'h0000_0FFC}, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check("m64_nbeats", tx_q.size() - q0, 64'd2);
        if (tx_q.size() >= q0 + 2) begin
            check("m64_beat0", tx_q[q0], 64'h4A200001_02000002);
            check("m64_beat1", tx_q[q0+1], 64'h1234227D_D4C3B2A1);
        end
        check("m64_addr", {54'd0, re_addr}, 64'h3FF);
        check("m64_cpl", {32'd0, stat_cpl_cnt}, 64'd2);

        // backpressure and buffer starvation
        q0 = tx_q.size();
        trn_bus.trn_tbuf_av = 6'd0;
        trn_bus.trn_tdst_rdy_n = 1'b1;
        mrd32(32'h20, 8'h07, 4'b0001, 16'h0100, 3'd0);
        repeat (4) begin @(posedge clk); #1; end
        check("bp_nobuf", {62'd0, trn_bus.trn_tsrc_rdy_n, trn_bus.trn_tsof_n}, 64'h3);
        check("bp_busy", {63'd0, busy}, 64'd1);
        trn_bus.trn_tbuf_av = 6'd4;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_tx0_td", trn_bus.trn_td, 64'h4A000001_02000001);
            check("bp_tx0_ctl", {61'd0, trn_bus.trn_tsrc_rdy_n, trn_bus.trn_tsof_n, trn_bus.trn_teof_n}, 64'h1);
            @(posedge clk); #1;
        end
        trn_bus.trn_tdst_rdy_n = 1'b0;
        @(posedge clk); #1;
        trn_bus.trn_tdst_rdy_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_tx1_td", trn_bus.trn_td, 64'h01000720_BEBAFECA);
            check("bp_tx1_ctl", {61'd0, trn_bus.trn_tsrc_rdy_n, trn_bus.trn_tsof_n, trn_bus.trn_teof_n}, 64'h2);
            @(posedge clk); #1;
        end
        trn_bus.trn_tdst_rdy_n = 1'b0;
        wait_idle();
        check("bp_nbeats", tx_q.size() - q0, 64'd2);
        check("bp_cpl", {32'd0, stat_cpl_cnt}, 64'd3);

        // drops
        q0 = tx_q.size();
        send_beat({32'h40000004, 32'h0100000F}, 1'b1, 1'b0, 1'b0);
        send_beat(64'h01020304_05060708, 1'b0, 1'b0, 1'b0);
        send_beat(64'h11121314_15161718, 1'b0, 1'b0, 1'b0);
        send_beat(64'h21222324_25262728, 1'b0, 1'b1, 1'b0);
        check("drop_mwr", {32'd0, stat_drop_cnt}, 64'd1);
        check("drop_mwr_idle", {63'd0, busy}, 64'd0);
        send_beat({32'h00000002, 32'h0100000F}, 1'b1, 1'b0, 1'b0);
        send_beat({32'h10, 32'h0}, 1'b0, 1'b1, 1'b0);
        check("drop_len2", {32'd0, stat_drop_cnt}, 64'd2);
        trn_bus.trn_rbar_hit_n = 7'h7D;
        mrd32(32'h10, 8'h01, 4'b1111, 16'h0100, 3'd0);
        trn_bus.trn_rbar_hit_n = 7'h7E;
        check("drop_bar", {32'd0, stat_drop_cnt}, 64'd3);
        hdr = {32'h00000001, 32'h0100090F};
        send_beat(hdr, 1'b1, 1'b0, 1'b0);
        send_beat({32'h10, 32'h0}, 1'b0, 1'b1, 1'b1);
        check("drop_dsc", {32'd0, stat_drop_cnt}, 64'd4);
        check("drop_dsc_idle", {63'd0, busy}, 64'd0);
        send_beat(hdr, 1'b1, 1'b1, 1'b0);
        check("drop_sofeof", {32'd0, stat_drop_cnt}, 64'd5);
        repeat (6) begin @(posedge clk); #1; end
        check("drop_no_tx", tx_q.size() - q0, 64'd0);
        check("drop_cpl", {32'd0, stat_cpl_cnt}, 64'd3);

        // asynchronous reset in TX1
        trn_bus.trn_tdst_rdy_n = 1'b1;
        mrd32(32'h10, 8'h05, 4'b1111, 16'h0100, 3'd0);
        repeat (2) begin @(posedge clk); #1; end
        trn_bus.trn_tdst_rdy_n = 1'b0;
        @(posedge clk); #1;
        trn_bus.trn_tdst_rdy_n = 1'b1;
        #1;
        check("ar_in_tx1", {63'd0, trn_bus.trn_teof_n}, 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check("ar_td", trn_bus.trn_td, 64'd0);
        check("ar_ctl", {60'd0, trn_bus.trn_tsrc_rdy_n, trn_bus.trn_tsof_n, trn_bus.trn_teof_n, busy}, 64'hE);
        check("ar_cnt", {stat_cpl_cnt, stat_drop_cnt}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        trn_bus.trn_tdst_rdy_n = 1'b0;
        @(posedge clk); #1;
        q0 = tx_q.size();
        mrd32(32'h10, 8'h05, 4'b1111, 16'h0100, 3'd0);
        wait_idle();
        check("ar_nbeats", tx_q.size() - q0, 64'd2);
        if (tx_q.size() >= q0 + 2) begin
            check("ar_beat0", tx_q[q0], 64'h4A000001_02000004);
            check("ar_beat1", tx_q[q0+1], 64'h01000510_44332211);
        end
        check("ar_cpl", {stat_cpl_cnt, stat_drop_cnt}, {32'd1, 32'd0});

        // link down while waiting on memory
        q0 = tx_q.size();
        c0 = stat_cpl_cnt;
        d0 = stat_drop_cnt;
        mrd32(32'h20, 8'h09, 4'b1111, 16'h0100, 3'd0);
        @(posedge clk); #1;
        lnk_up_n = 1'b1;
        @(posedge clk); #1;
        check("ld_idle", {62'd0, busy, trn_bus.trn_tsrc_rdy_n}, 64'h1);
        lnk_up_n = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("ld_no_tx", tx_q.size() - q0, 64'd0);
        check("ld_cnt", {stat_cpl_cnt, stat_drop_cnt}, {c0[31:0], d0[31:0]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
